// File: rtl/pipe_ctrl_chain.sv
// Generic N-stage post-decode control pipeline with stall/flush, forwarding lookup and load-use detect; 1 stage per edge, a later-stage stall freezes all earlier stages.
// Optional PIPE_CTRL_PERF_CNT_EN adds retired/bubble counters.
module pipe_ctrl_chain #(
    parameter int NUM_STAGES = 3,
    parameter int CTRL_W     = 8,
    parameter int RD_W       = 5,
    parameter int FWD_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    input  logic [CTRL_W-1:0]            in_ctrl_i,
    input  logic [RD_W-1:0]              in_rd_i,
    input  logic                         in_reg_write_i,
    input  logic                         in_mem_read_i,
    input  logic [RD_W-1:0]              rs1_i,
    input  logic [RD_W-1:0]              rs2_i,
    input  logic [NUM_STAGES-1:0]        stall_i,
    input  logic [NUM_STAGES-1:0]        flush_i,
    output logic [NUM_STAGES-1:0]        stage_valid_o,
    output logic [NUM_STAGES*CTRL_W-1:0] stage_ctrl_o,
    output logic [NUM_STAGES*RD_W-1:0]   stage_rd_o,
    output logic                         retire_o,
    output logic [RD_W-1:0]              retire_rd_o,
    output logic [FWD_W-1:0]             fwd_rs1_o,
    output logic [FWD_W-1:0]             fwd_rs2_o,
    output logic                         load_use_o
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]                  retired_cnt_o,
    output logic [31:0]                  bubble_cnt_o
`endif
);

    logic [NUM_STAGES-1:0] r_valid;
    logic [NUM_STAGES-1:0] r_rw;
    logic [NUM_STAGES-1:0] r_mr;
    logic [CTRL_W-1:0]     r_ctrl [NUM_STAGES];
    logic [RD_W-1:0]       r_rd   [NUM_STAGES];

    logic [NUM_STAGES-1:0] w_hold;
    logic [NUM_STAGES-1:0] w_up_hold;
    logic [NUM_STAGES-1:0] w_src_valid;
    logic [NUM_STAGES-1:0] w_src_rw;
    logic [NUM_STAGES-1:0] w_src_mr;
    logic [CTRL_W-1:0]     w_src_ctrl [NUM_STAGES];
    logic [RD_W-1:0]       w_src_rd   [NUM_STAGES];
    logic                  w_load_use;

    // A stall anywhere downstream freezes this stage too.
    always_comb begin
        w_hold = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            w_hold[k] = |(stall_i >> k);
        end
    end

    // Bit k is set when the stage feeding stage k is frozen; stage 0 has no upstream hold.
    assign w_up_hold = {w_hold[NUM_STAGES-2:0], 1'b0};

    assign w_load_use = r_valid[0] & r_mr[0] & (r_rd[0] != '0) &
                        ((r_rd[0] == rs1_i) | (r_rd[0] == rs2_i));

    assign w_src_valid = {r_valid[NUM_STAGES-2:0], in_valid_i & ~w_load_use};
    assign w_src_rw    = {r_rw[NUM_STAGES-2:0], in_reg_write_i};
    assign w_src_mr    = {r_mr[NUM_STAGES-2:0], in_mem_read_i};

    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            w_src_ctrl[k] = '0;
            w_src_rd[k]   = '0;
        end
        w_src_ctrl[0] = in_ctrl_i;
        w_src_rd[0]   = in_rd_i;
        for (int k = 1; k < NUM_STAGES; k++) begin
            w_src_ctrl[k] = r_ctrl[k-1];
            w_src_rd[k]   = r_rd[k-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_rw    <= '0;
            r_mr    <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_ctrl[k] <= '0;
                r_rd[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (flush_i[k]) begin
                    r_valid[k] <= 1'b0;
                    r_rw[k]    <= 1'b0;
                    r_mr[k]    <= 1'b0;
                end else if (w_hold[k]) begin
                    r_valid[k] <= r_valid[k];
                end else if (w_up_hold[k]) begin
                    r_valid[k] <= 1'b0;
                    r_rw[k]    <= 1'b0;
                    r_mr[k]    <= 1'b0;
                end else begin
                    // Invalid entries carry cleared write/load bits so they can never gate anything.
                    r_valid[k] <= w_src_valid[k];
                    r_rw[k]    <= w_src_rw[k] & w_src_valid[k];
                    r_mr[k]    <= w_src_mr[k] & w_src_valid[k];
                    r_ctrl[k]  <= w_src_ctrl[k];
                    r_rd[k]    <= w_src_rd[k];
                end
            end
        end
    end

    always_comb begin
        stage_ctrl_o = '0;
        stage_rd_o   = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            stage_ctrl_o[k*CTRL_W +: CTRL_W] = r_ctrl[k];
            stage_rd_o[k*RD_W +: RD_W]       = r_rd[k];
        end
    end

    // Scan oldest to youngest so the youngest match overwrites.
    always_comb begin
        fwd_rs1_o = '0;
        fwd_rs2_o = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (r_valid[k] && r_rw[k] && (r_rd[k] == rs1_i) && (rs1_i != '0)) begin
                fwd_rs1_o = FWD_W'(k + 1);
            end
            if (r_valid[k] && r_rw[k] && (r_rd[k] == rs2_i) && (rs2_i != '0)) begin
                fwd_rs2_o = FWD_W'(k + 1);
            end
        end
    end

    assign stage_valid_o = r_valid;
    assign retire_o      = r_valid[NUM_STAGES-1] & r_rw[NUM_STAGES-1];
    assign retire_rd_o   = r_rd[NUM_STAGES-1];
    assign load_use_o    = w_load_use;

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] r_retired_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_retired_cnt <= '0;
            r_bubble_cnt  <= '0;
        end else begin
            if (retire_o) begin
                r_retired_cnt <= r_retired_cnt + 32'd1;
            end
            if (in_valid_i && (w_load_use || w_hold[0])) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign retired_cnt_o = r_retired_cnt;
    assign bubble_cnt_o  = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Bench for pipe_ctrl_chain: directed scenarios plus randomized traffic against an entry-level queue model.
`timescale 1ns/1ps
module tb_pipe_ctrl_chain;
    localparam int N  = 3;
    localparam int CW = 8;
    localparam int RW = 5;
    localparam int FW = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              in_valid_i;
    logic [CW-1:0]     in_ctrl_i;
    logic [RW-1:0]     in_rd_i;
    logic              in_reg_write_i;
    logic              in_mem_read_i;
    logic [RW-1:0]     rs1_i;
    logic [RW-1:0]     rs2_i;
    logic [N-1:0]      stall_i;
    logic [N-1:0]      flush_i;
    logic [N-1:0]      stage_valid_o;
    logic [N*CW-1:0]   stage_ctrl_o;
    logic [N*RW-1:0]   stage_rd_o;
    logic              retire_o;
    logic [RW-1:0]     retire_rd_o;
    logic [FW-1:0]     fwd_rs1_o;
    logic [FW-1:0]     fwd_rs2_o;
    logic              load_use_o;
`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0]       retired_cnt_o;
    logic [31:0]       bubble_cnt_o;
    logic [31:0]       exp_ret;
    logic [31:0]       exp_bub;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          v;
        logic [7:0]  ctrl;
        logic [4:0]  rd;
        bit          rw;
        bit          mr;
    } ent_t;

    ent_t m [N];

    pipe_ctrl_chain #(.NUM_STAGES(N), .CTRL_W(CW), .RD_W(RW), .FWD_W(FW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ctrl_i(in_ctrl_i), .in_rd_i(in_rd_i),
        .in_reg_write_i(in_reg_write_i), .in_mem_read_i(in_mem_read_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .stall_i(stall_i), .flush_i(flush_i),
        .stage_valid_o(stage_valid_o), .stage_ctrl_o(stage_ctrl_o), .stage_rd_o(stage_rd_o),
        .retire_o(retire_o), .retire_rd_o(retire_rd_o),
        .fwd_rs1_o(fwd_rs1_o), .fwd_rs2_o(fwd_rs2_o), .load_use_o(load_use_o)
`ifdef PIPE_CTRL_PERF_CNT_EN
        , .retired_cnt_o(retired_cnt_o), .bubble_cnt_o(bubble_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic int model_fwd(input logic [4:0] rs);
        for (int k = 0; k < N; k++) begin
            if (m[k].v && m[k].rw && m[k].rd == rs && rs != 0) return k + 1;
        end
        return 0;
    endfunction

    function automatic bit model_lu();
        return m[0].v && m[0].mr && m[0].rd != 0 && (m[0].rd == rs1_i || m[0].rd == rs2_i);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N; k++) m[k] = '{v: 0, ctrl: 0, rd: 0, rw: 0, mr: 0};
`ifdef PIPE_CTRL_PERF_CNT_EN
        exp_ret = 0;
        exp_bub = 0;
`endif
    endtask

    task automatic idle();
        in_valid_i = 0; in_ctrl_i = 0; in_rd_i = 0; in_reg_write_i = 0; in_mem_read_i = 0;
        rs1_i = 0; rs2_i = 0; stall_i = 0; flush_i = 0;
    endtask

    task automatic drive(input bit v, input logic [7:0] c, input logic [4:0] rd, input bit rw, input bit mr);
        in_valid_i = v; in_ctrl_i = c; in_rd_i = rd; in_reg_write_i = rw; in_mem_read_i = mr;
    endtask

    // Advance one edge: model computes the next pipeline contents from the current inputs.
    task automatic tick();
        ent_t nx [N];
        bit [N-1:0] hold;
        bit lu;
        lu = model_lu();
        for (int k = 0; k < N; k++) begin
            hold[k] = 0;
            for (int j = k; j < N; j++) if (stall_i[j]) hold[k] = 1;
        end
`ifdef PIPE_CTRL_PERF_CNT_EN
        if (m[N-1].v && m[N-1].rw) exp_ret = exp_ret + 1;
        if (in_valid_i && (lu || hold[0])) exp_bub = exp_bub + 1;
`endif
        for (int k = 0; k < N; k++) begin
            nx[k] = m[k];
            if (flush_i[k]) nx[k].v = 0;
            else if (hold[k]) nx[k] = m[k];
            else if (k == 0) begin
                if (lu) nx[0].v = 0;
                else nx[0] = '{v: in_valid_i, ctrl: in_ctrl_i, rd: in_rd_i, rw: in_reg_write_i, mr: in_mem_read_i};
            end else if (hold[k-1]) nx[k].v = 0;
            else nx[k] = m[k-1];
        end
        @(posedge clk_i);
        for (int k = 0; k < N; k++) m[k] = nx[k];
        #1;
    endtask

    task automatic fill3();
        drive(1, 8'hC3, 5'd3, 1, 0); tick();
        drive(1, 8'hB2, 5'd2, 1, 0); tick();
        drive(1, 8'hA1, 5'd1, 1, 0); tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1; rs1_i = 5; rs2_i = 5;
        model_clear();
        #12;
        checks++; if (stage_valid_o !== 3'b000) begin errors++; $display("FAIL reset_valid: got %b expected 000", stage_valid_o); end
        checks++; if (retire_o !== 1'b0) begin errors++; $display("FAIL reset_retire: got %b expected 0", retire_o); end
        checks++; if (fwd_rs1_o !== 2'd0 || fwd_rs2_o !== 2'd0) begin errors++; $display("FAIL reset_fwd: got %0d/%0d expected 0/0", fwd_rs1_o, fwd_rs2_o); end
        checks++; if (load_use_o !== 1'b0) begin errors++; $display("FAIL reset_load_use: got %b expected 0", load_use_o); end
`ifdef PIPE_CTRL_PERF_CNT_EN
        checks++; if (retired_cnt_o !== 0 || bubble_cnt_o !== 0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", retired_cnt_o, bubble_cnt_o); end
`endif
        @(negedge clk_i); rst_i = 0; idle();
    endtask

    task automatic test_walk();
        drive(1, 8'hA5, 5'd5, 1, 0); tick(); idle();
        checks++; if (stage_valid_o !== 3'b001) begin errors++; $display("FAIL walk_v1: got %b expected 001", stage_valid_o); end
        checks++; if (stage_ctrl_o[7:0] !== 8'hA5) begin errors++; $display("FAIL walk_c0: got %h expected a5", stage_ctrl_o[7:0]); end
        checks++; if (retire_o !== 1'b0) begin errors++; $display("FAIL walk_r1: got %b expected 0", retire_o); end
        tick();
        checks++; if (stage_valid_o !== 3'b010) begin errors++; $display("FAIL walk_v2: got %b expected 010", stage_valid_o); end
        checks++; if (stage_ctrl_o[15:8] !== 8'hA5) begin errors++; $display("FAIL walk_c1: got %h expected a5", stage_ctrl_o[15:8]); end
        tick();
        checks++; if (stage_valid_o !== 3'b100) begin errors++; $display("FAIL walk_v3: got %b expected 100", stage_valid_o); end
        checks++; if (stage_ctrl_o[23:16] !== 8'hA5) begin errors++; $display("FAIL walk_c2: got %h expected a5", stage_ctrl_o[23:16]); end
        checks++; if (retire_o !== 1'b1 || retire_rd_o !== 5'd5) begin errors++; $display("FAIL walk_retire: got %b rd %0d expected 1 rd 5", retire_o, retire_rd_o); end
        tick();
        checks++; if (stage_valid_o !== 3'b000 || retire_o !== 1'b0) begin errors++; $display("FAIL walk_drain: got %b/%b expected 000/0", stage_valid_o, retire_o); end
    endtask

    task automatic test_forward();
        drive(1, 8'h01, 5'd7, 1, 0); tick();
        drive(1, 8'h02, 5'd7, 1, 0); tick(); idle();
        rs1_i = 7; #1;
        checks++; if (fwd_rs1_o !== 2'd1) begin errors++; $display("FAIL fwd_youngest: got %0d expected 1", fwd_rs1_o); end
        flush_i = 3'b001; tick(); flush_i = 0; #1;
        checks++; if (fwd_rs1_o !== 2'd2) begin errors++; $display("FAIL fwd_after_flush: got %0d expected 2", fwd_rs1_o); end
        rs1_i = 0; #1;
        checks++; if (fwd_rs1_o !== 2'd0) begin errors++; $display("FAIL fwd_x0: got %0d expected 0", fwd_rs1_o); end
        flush_i = 3'b111; tick(); idle();
    endtask

    task automatic test_load_use();
        drive(1, 8'h90, 5'd9, 1, 1); tick();
        drive(1, 8'h33, 5'd3, 1, 0); rs2_i = 9; #1;
        checks++; if (load_use_o !== 1'b1) begin errors++; $display("FAIL lu_detect: got %b expected 1", load_use_o); end
        tick();
        checks++; if (stage_valid_o !== 3'b010) begin errors++; $display("FAIL lu_bubble: got %b expected 010", stage_valid_o); end
        checks++; if (load_use_o !== 1'b0) begin errors++; $display("FAIL lu_clear: got %b expected 0", load_use_o); end
        checks++; if (fwd_rs2_o !== 2'd2) begin errors++; $display("FAIL lu_fwd: got %0d expected 2", fwd_rs2_o); end
        tick(); idle();
        checks++; if (stage_valid_o !== 3'b101 || stage_ctrl_o[7:0] !== 8'h33 || stage_rd_o[4:0] !== 5'd3) begin
            errors++; $display("FAIL lu_accept: got %b ctrl %h rd %0d expected 101 ctrl 33 rd 3", stage_valid_o, stage_ctrl_o[7:0], stage_rd_o[4:0]);
        end
        flush_i = 3'b111; tick(); idle();
    endtask

    task automatic test_stall_last();
        logic [4:0] exp_rd [3];
        exp_rd[0] = 5'd2; exp_rd[1] = 5'd1; exp_rd[2] = 5'd0;
        fill3();
        stall_i = 3'b100;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (stage_valid_o !== 3'b111 || stage_ctrl_o[7:0] !== 8'hA1) begin errors++; $display("FAIL stall2_frozen: got %b ctrl0 %h expected 111 ctrl0 a1", stage_valid_o, stage_ctrl_o[7:0]); end
            checks++; if (retire_o !== 1'b1 || retire_rd_o !== 5'd3) begin errors++; $display("FAIL stall2_retire: got %b rd %0d expected 1 rd 3", retire_o, retire_rd_o); end
        end
        stall_i = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (retire_o !== (exp_rd[i] != 0) || (exp_rd[i] != 0 && retire_rd_o !== exp_rd[i])) begin
                errors++; $display("FAIL stall2_release%0d: got %b rd %0d expected rd %0d", i, retire_o, retire_rd_o, exp_rd[i]);
            end
        end
    endtask

    task automatic test_stall_mid();
        fill3();
        checks++; if (retire_o !== 1'b1 || retire_rd_o !== 5'd3) begin errors++; $display("FAIL stall1_c: got %b rd %0d expected 1 rd 3", retire_o, retire_rd_o); end
        stall_i = 3'b010; tick(); stall_i = 0;
        checks++; if (stage_valid_o !== 3'b011 || retire_o !== 1'b0) begin errors++; $display("FAIL stall1_bubble: got %b/%b expected 011/0", stage_valid_o, retire_o); end
        checks++; if (stage_ctrl_o[15:0] !== 16'hB2A1) begin errors++; $display("FAIL stall1_hold: got %h expected b2a1", stage_ctrl_o[15:0]); end
        tick();
        checks++; if (retire_o !== 1'b1 || retire_rd_o !== 5'd2) begin errors++; $display("FAIL stall1_b: got %b rd %0d expected 1 rd 2", retire_o, retire_rd_o); end
        tick();
        checks++; if (retire_o !== 1'b1 || retire_rd_o !== 5'd1) begin errors++; $display("FAIL stall1_a: got %b rd %0d expected 1 rd 1", retire_o, retire_rd_o); end
        tick();
    endtask

    task automatic test_async_reset();
        fill3();
        checks++; if (stage_valid_o !== 3'b111) begin errors++; $display("FAIL areset_pre: got %b expected 111", stage_valid_o); end
        #2 rst_i = 1;
        #1;
        checks++; if (stage_valid_o !== 3'b000 || retire_o !== 1'b0) begin errors++; $display("FAIL areset: got %b/%b expected 000/0", stage_valid_o, retire_o); end
`ifdef PIPE_CTRL_PERF_CNT_EN
        checks++; if (retired_cnt_o !== 0 || bubble_cnt_o !== 0) begin errors++; $display("FAIL areset_cnt: got %0d/%0d expected 0/0", retired_cnt_o, bubble_cnt_o); end
`endif
        model_clear();
        @(negedge clk_i); rst_i = 0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            drive(($urandom % 4) != 0, 8'($urandom), 5'($urandom % 8), ($urandom % 4) != 0, ($urandom % 3) == 0);
            rs1_i = 5'($urandom % 8);
            rs2_i = 5'($urandom % 8);
            for (int k = 0; k < N; k++) begin
                stall_i[k] = ($urandom % 8) == 0;
                flush_i[k] = ($urandom % 10) == 0;
            end
            #1;
            checks++; if (int'(fwd_rs1_o) !== model_fwd(rs1_i)) begin errors++; $display("FAIL rnd_fwd1 it%0d: got %0d expected %0d", it, fwd_rs1_o, model_fwd(rs1_i)); end
            checks++; if (int'(fwd_rs2_o) !== model_fwd(rs2_i)) begin errors++; $display("FAIL rnd_fwd2 it%0d: got %0d expected %0d", it, fwd_rs2_o, model_fwd(rs2_i)); end
            checks++; if (load_use_o !== model_lu()) begin errors++; $display("FAIL rnd_lu it%0d: got %b expected %b", it, load_use_o, model_lu()); end
            checks++; if (retire_o !== (m[N-1].v && m[N-1].rw)) begin errors++; $display("FAIL rnd_retire it%0d: got %b expected %b", it, retire_o, m[N-1].v && m[N-1].rw); end
            for (int k = 0; k < N; k++) begin
                checks++; if (stage_valid_o[k] !== m[k].v) begin errors++; $display("FAIL rnd_valid%0d it%0d: got %b expected %b", k, it, stage_valid_o[k], m[k].v); end
                if (m[k].v) begin
                    checks++; if (stage_ctrl_o[k*CW +: CW] !== m[k].ctrl || stage_rd_o[k*RW +: RW] !== m[k].rd) begin
                        errors++; $display("FAIL rnd_data%0d it%0d: got %h/%0d expected %h/%0d", k, it, stage_ctrl_o[k*CW +: CW], stage_rd_o[k*RW +: RW], m[k].ctrl, m[k].rd);
                    end
                end
            end
            tick();
        end
        idle();
`ifdef PIPE_CTRL_PERF_CNT_EN
        #1;
        checks++; if (retired_cnt_o !== exp_ret) begin errors++; $display("FAIL rnd_retired_cnt: got %0d expected %0d", retired_cnt_o, exp_ret); end
        checks++; if (bubble_cnt_o !== exp_bub) begin errors++; $display("FAIL rnd_bubble_cnt: got %0d expected %0d", bubble_cnt_o, exp_bub); end
`endif
    endtask

    initial begin
        test_reset();
        test_walk();
        test_forward();
        test_load_use();
        test_stall_last();
        test_stall_mid();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
